// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX serializer between NUM_REQ byte sources,
// with per-frame locking (req_last) and forced release of idle locks.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int LOCK_TIMEOUT = 1024
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          tx_start,
   output logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_done,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy,
   output logic                          lock_timeout,
   output logic [1:0]                    dbg_state
);

   localparam int GW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]         grant_q, grant_d;
   logic                  lock_q, lock_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  lto_q, lto_d;

   logic                  found;
   logic                  own_valid;
   logic [GW-1:0]         win;
   logic [DATA_WIDTH-1:0] win_data;
   logic                  win_last;

   function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
      int n;
      n = (int'(idx) + 1) % NUM_REQ;
      return GW'(n);
   endfunction

   // Handshake: a byte moves when req_valid[i] & req_ready[i] are both high at a
   // rising edge; req_ready is only ever raised for the single winner in IDLE.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      grant_d   = grant_q;
      lock_d    = lock_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      lto_d     = 1'b0;
      req_ready = '0;
      found     = 1'b0;
      own_valid = 1'b0;
      win       = grant_q;
      win_data  = '0;
      win_last  = 1'b0;

      for (int i = 0; i < NUM_REQ; i++) begin
         if (GW'(i) == grant_q) own_valid = req_valid[i];
      end

      // A held lock excludes everyone else, including in the cycle the lock drops.
      if (lock_q) begin
         found = own_valid;
         win   = grant_q;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (!found && req_valid[i] && ((int'(rr_ptr_q) + k) % NUM_REQ == i)) begin
                  found = 1'b1;
                  win   = GW'(i);
               end
            end
         end
      end

      for (int i = 0; i < NUM_REQ; i++) begin
         if (GW'(i) == win) begin
            win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            win_last = req_last[i];
         end
      end

      case (state_q)
         S_IDLE: begin
            if (found) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (GW'(i) == win) req_ready[i] = 1'b1;
               end
               data_d  = win_data;
               grant_d = win;
               state_d = S_START;
               cnt_d   = '0;
               if (win_last) begin
                  lock_d   = 1'b0;
                  rr_ptr_d = next_idx(win);
               end else begin
                  lock_d = 1'b1;
               end
            end else if (lock_q) begin
               if (cnt_q == 16'(LOCK_TIMEOUT - 1)) begin
                  lock_d   = 1'b0;
                  rr_ptr_d = next_idx(grant_q);
                  cnt_d    = '0;
                  lto_d    = 1'b1;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         S_START: state_d = S_WAIT;
         S_WAIT: begin
            if (tx_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         lock_q   <= 1'b0;
         data_q   <= '0;
         cnt_q    <= '0;
         lto_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         lock_q   <= lock_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         lto_q    <= lto_d;
      end
   end

   assign tx_start     = (state_q == S_START);
   assign busy         = (state_q != S_IDLE);
   assign tx_data      = data_q;
   assign grant_id     = grant_q;
   assign lock_timeout = lto_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-source byte queues drive the requesters,
// a monitor checks every tx_start against the expected character queue.
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int LT = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [NR-1:0]   req_valid = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic [NR-1:0]   req_last = '0;
   logic [NR-1:0]   req_ready;
   logic            tx_start;
   logic [DW-1:0]   tx_data;
   logic            tx_done;
   logic [1:0]      grant_id;
   logic            busy;
   logic            lock_timeout;
   logic [1:0]      dbg_state;

   logic            ser_done = 1'b0;
   logic            man_done = 1'b0;
   logic            ser_en = 1'b1;

   int              n_vec = 0;
   int              n_err = 0;
   logic [9:0]      exp_q[$];
   logic [8:0]      src_q[NR][$];

   assign tx_done = ser_done | man_done;

   uart_tx_arbiter #(
      .NUM_REQ(NR), .DATA_WIDTH(DW), .LOCK_TIMEOUT(LT)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
      .tx_done(tx_done), .grant_id(grant_id), .busy(busy),
      .lock_timeout(lock_timeout), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   // serializer model: tx_done ten cycles after tx_start
   initial begin
      forever begin
         @(negedge clk);
         if (tx_start && ser_en) begin
            repeat (10) @(posedge clk);
            #1 ser_done = 1'b1;
            @(posedge clk);
            #1 ser_done = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_src(input int i, input logic l, input logic [7:0] d);
      src_q[i].push_back({l, d});
   endtask

   task automatic push_exp(input logic [1:0] gid, input logic [7:0] d);
      exp_q.push_back({gid, d});
   endtask

   // scoreboard monitor
   task automatic monitor();
      logic [9:0] e;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_tx_start", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("tx_data", 32'(tx_data), 32'(e[7:0]));
               check("grant_id", 32'(grant_id), 32'(e[9:8]));
            end
         end
      end
   endtask

   // requester driver: each source presents the head of its queue until accepted
   task automatic driver();
      logic [NR-1:0]    hs, v, l;
      logic [NR*DW-1:0] d;
      logic [8:0]       h;
      forever begin
         @(negedge clk);
         hs = req_valid & req_ready;
         @(posedge clk);
         #1;
         v = '0; l = '0; d = '0;
         for (int i = 0; i < NR; i++) begin
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
               h = src_q[i][0];
               v[i] = 1'b1;
               l[i] = h[8];
               d[i*DW +: DW] = h[7:0];
            end
         end
         req_valid = v;
         req_last  = l;
         req_data  = d;
      end
   endtask

   task automatic wait_ready(output logic [NR-1:0] rdy);
      rdy = '0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            rdy = req_ready;
            break;
         end
      end
   endtask

   task automatic wait_drain(input string name);
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy && req_valid == '0) break;
      end
      check(name, 32'((exp_q.size() != 0) || busy || (req_valid != '0)), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      logic [NR-1:0] rdy;
      int            k;
      int            n_idle;

      fork
         monitor();
         driver();
      join_none

      repeat (3) cyc();
      @(negedge clk);
      check("rst_tx_start", 32'(tx_start), 0);
      check("rst_tx_data", 32'(tx_data), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_grant_id", 32'(grant_id), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_lock_timeout", 32'(lock_timeout), 0);
      cyc();
      reset = 1'b0;

      // single byte from requester 2
      @(negedge clk);
      push_src(2, 1'b1, 8'hA5);
      push_exp(2'd2, 8'hA5);
      wait_ready(rdy);
      check("t1_ready", 32'(rdy), 32'h4);
      @(negedge clk);
      check("t1_start_busy", 32'({tx_start, busy}), 32'h3);
      wait_drain("t1_drain");

      // pointer now at 3: requester 3 beats requester 0
      @(negedge clk);
      push_src(0, 1'b1, 8'hB0);
      push_src(3, 1'b1, 8'hB3);
      push_exp(2'd3, 8'hB3);
      push_exp(2'd0, 8'hB0);
      wait_ready(rdy);
      check("t1b_ready", 32'(rdy), 32'h8);
      wait_drain("t1b_drain");

      // round robin over all four sources
      do_reset();
      @(negedge clk);
      push_src(0, 1'b1, 8'h10);
      push_src(0, 1'b1, 8'h10);
      push_src(1, 1'b1, 8'h11);
      push_src(2, 1'b1, 8'h12);
      push_src(3, 1'b1, 8'h13);
      push_exp(2'd0, 8'h10);
      push_exp(2'd1, 8'h11);
      push_exp(2'd2, 8'h12);
      push_exp(2'd3, 8'h13);
      push_exp(2'd0, 8'h10);
      wait_drain("t2_drain");

      // frame lock by requester 1 while 0 and 2 wait
      @(negedge clk);
      push_src(1, 1'b0, 8'h41);
      push_src(1, 1'b0, 8'h42);
      push_src(1, 1'b1, 8'h43);
      push_src(0, 1'b1, 8'h30);
      push_src(2, 1'b1, 8'h32);
      push_exp(2'd1, 8'h41);
      push_exp(2'd1, 8'h42);
      push_exp(2'd1, 8'h43);
      push_exp(2'd2, 8'h32);
      push_exp(2'd0, 8'h30);
      wait_drain("t3_drain");

      // abandoned lock is force-released after LT idle cycles
      @(negedge clk);
      push_src(1, 1'b0, 8'h55);
      push_src(0, 1'b1, 8'h60);
      push_exp(2'd1, 8'h55);
      push_exp(2'd0, 8'h60);
      wait_ready(rdy);
      check("t4_ready_lock", 32'(rdy), 32'h2);
      k = 0;
      @(negedge clk);
      while (busy && k < 100) begin
         @(negedge clk);
         k++;
      end
      n_idle = 0;
      while (!lock_timeout && n_idle < 40) begin
         n_idle++;
         @(negedge clk);
      end
      check("t4_idle_cycles", 32'(n_idle), 32'(LT));
      check("t4_ready_after", 32'(req_ready), 32'h1);
      @(negedge clk);
      check("t4_pulse_width", 32'(lock_timeout), 0);
      check("t4_start_after", 32'(tx_start), 1);
      wait_drain("t4_drain");

      // reset while waiting on the serializer
      ser_en = 1'b0;
      @(negedge clk);
      push_src(2, 1'b1, 8'h77);
      push_exp(2'd2, 8'h77);
      wait_ready(rdy);
      check("t5_ready", 32'(rdy), 32'h4);
      @(negedge clk);
      repeat (3) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      @(negedge clk);
      check("t5_rst_outputs", 32'({tx_start, busy, lock_timeout, grant_id, req_ready, tx_data}), 0);
      cyc();
      man_done = 1'b1;
      cyc();
      man_done = 1'b0;
      @(negedge clk);
      check("t5_late_done", 32'({tx_start, busy}), 0);
      ser_en = 1'b1;
      push_src(1, 1'b1, 8'h81);
      push_src(3, 1'b1, 8'h83);
      push_exp(2'd1, 8'h81);
      push_exp(2'd3, 8'h83);
      wait_ready(rdy);
      check("t5_ready_after", 32'(rdy), 32'h2);
      wait_drain("t5_drain");

      // tx_done outside WAIT must not complete a character
      ser_en = 1'b0;
      cyc();
      man_done = 1'b1;
      cyc();
      man_done = 1'b0;
      @(negedge clk);
      check("t6_idle_done", 32'({tx_start, busy}), 0);
      push_src(0, 1'b1, 8'h99);
      push_exp(2'd0, 8'h99);
      wait_ready(rdy);
      check("t6_ready", 32'(rdy), 32'h1);
      cyc();
      man_done = 1'b1;
      cyc();
      man_done = 1'b0;
      @(negedge clk);
      check("t6_start_done", 32'({tx_start, busy}), 32'h1);
      repeat (5) cyc();
      @(negedge clk);
      check("t6_wait_hold", 32'({busy, tx_data}), 32'h199);
      cyc();
      man_done = 1'b1;
      cyc();
      man_done = 1'b0;
      @(negedge clk);
      check("t6_wait_done", 32'(busy), 0);
      ser_en = 1'b1;
      wait_drain("t6_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
